// File: rtl/pipe_stage_skid.sv
// Generic pipeline register with valid/ready handshake, 2-entry skid buffer, flush and bubble clearing.
// Optional performance counters are enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_skid #(
  parameter int CTRL_W     = 16,
  parameter int DATA_W     = 128,
  parameter bit CLEAR_CTRL = 1'b1,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              valid_in,
  output logic              ready_out,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              valid_out,
  input  logic              ready_in,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [DATA_W-1:0] data_out,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } beat_t;

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] BUSY  = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0] state, state_nx;
  beat_t      main_q, skid_q, in_beat;
  logic       acc, take;
  logic       ld_main_in, ld_main_skid, ld_skid;

  assign in_beat   = '{ctrl: ctrl_in, data: data_in};
  // ready_out comes straight from the state flop: no path from ready_in
  assign ready_out = (state != FULL);
  assign valid_out = (state != EMPTY);
  assign acc       = valid_in & ready_out;
  assign take      = valid_out & ready_in;

  always_comb begin
    state_nx     = state;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    case (state)
      EMPTY: if (acc) begin
        ld_main_in = 1'b1;
        state_nx   = BUSY;
      end
      BUSY: begin
        if (acc && take) begin
          ld_main_in = 1'b1;
        end else if (acc) begin
          ld_skid  = 1'b1;
          state_nx = FULL;
        end else if (take) begin
          state_nx = EMPTY;
        end
      end
      FULL: if (take) begin
        ld_main_skid = 1'b1;
        state_nx     = BUSY;
      end
      default: state_nx = EMPTY;
    endcase
  end

  // Flush blocks every register load so main keeps its last payload for data_out.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      state <= state_nx;
      if (ld_main_in)        main_q <= in_beat;
      else if (ld_main_skid) main_q <= skid_q;
      if (ld_skid)           skid_q <= in_beat;
    end
  end

  assign ctrl_out = (CLEAR_CTRL && !valid_out) ? '0 : main_q.ctrl;
  assign data_out = main_q.data;

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] stall_q, flush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (valid_out && !ready_in)                stall_q <= stall_q + CNT_W'(1);
      if (flush && ((state != EMPTY) || acc))    flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: queue-based reference model plus directed literal checks and random traffic.
module tb_pipe_stage_skid;
  localparam int CW = 16;
  localparam int DW = 32;
  localparam int NW = 4;

  logic          clk = 1'b0;
  logic          rst, flush, valid_in, ready_in;
  logic          ready_out, valid_out;
  logic [CW-1:0] ctrl_in, ctrl_out;
  logic [DW-1:0] data_in, data_out;
  logic [NW-1:0] stall_cnt, flush_cnt;

  pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .CLEAR_CTRL(1'b1), .CNT_W(NW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .valid_in(valid_in), .ready_out(ready_out),
    .ctrl_in(ctrl_in), .data_in(data_in), .valid_out(valid_out), .ready_in(ready_in),
    .ctrl_out(ctrl_out), .data_out(data_out), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } beat_t;

  // Model: the stage is a FIFO of depth 2; data_out remembers the last head.
  beat_t         q[$];
  logic [DW-1:0] m_last = '0;
  int            m_stall = 0, m_flush = 0;
  int            total = 0, bad = 0;
  bit            chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit acc, take;
    acc  = valid_in && (q.size() < 2);
    take = (q.size() > 0) && ready_in;
    if (rst) begin
      q.delete();
      m_last  = '0;
      m_stall = 0;
      m_flush = 0;
    end else begin
      if (q.size() > 0 && !ready_in)        m_stall = (m_stall + 1) % (1 << NW);
      if (flush && (q.size() > 0 || acc))   m_flush = (m_flush + 1) % (1 << NW);
      if (flush) q.delete();
      else begin
        if (take) void'(q.pop_front());
        if (acc)  q.push_back('{ctrl_in, data_in});
      end
      if (q.size() > 0) m_last = q[0].d;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("valid_out", 64'(valid_out), 64'(q.size() > 0));
      chk("ready_out", 64'(ready_out), 64'(q.size() < 2));
      chk("ctrl_out",  64'(ctrl_out),  (q.size() > 0) ? 64'(q[0].c) : 64'd0);
      chk("data_out",  64'(data_out),  (q.size() > 0) ? 64'(q[0].d) : 64'(m_last));
`ifdef PIPE_STAGE_PERF_EN
      chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
      chk("flush_cnt", 64'(flush_cnt), 64'(m_flush));
`else
      chk("stall_cnt", 64'(stall_cnt), 64'd0);
      chk("flush_cnt", 64'(flush_cnt), 64'd0);
`endif
    end
  end

  task automatic step(input bit r, input bit f, input bit v, input bit rdy,
                      input logic [CW-1:0] c, input logic [DW-1:0] d);
    rst = r; flush = f; valid_in = v; ready_in = rdy; ctrl_in = c; data_in = d;
    @(posedge clk);
    model_edge();
    chk_en = 1'b1;
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; valid_in = 1'b0; ready_in = 1'b0; ctrl_in = '0; data_in = '0;

    // Reset values
    step(1, 0, 0, 0, 16'h0, 32'h0);
    chk("rst_valid", 64'(valid_out), 64'd0);
    chk("rst_ready", 64'(ready_out), 64'd1);
    chk("rst_ctrl",  64'(ctrl_out),  64'd0);
    chk("rst_data",  64'(data_out),  64'd0);

    // Stall counting and wrap (CNT_W=4: 17 -> 1)
    step(0, 0, 1, 0, 16'h0011, 32'h1111_0000);
    chk("stall_hold_ctrl", 64'(ctrl_out), 64'h0011);
    for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 16'h0, 32'h0);
`ifdef PIPE_STAGE_PERF_EN
    chk("stall_7", 64'(stall_cnt), 64'd7);
`endif
    chk("stall_data_stable", 64'(data_out), 64'h1111_0000);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 16'h0, 32'h0);
`ifdef PIPE_STAGE_PERF_EN
    chk("stall_wrap", 64'(stall_cnt), 64'd1);
`endif
    step(0, 0, 0, 1, 16'h0, 32'h0);
    chk("drain_valid", 64'(valid_out), 64'd0);
    chk("bubble_data_held", 64'(data_out), 64'h1111_0000);

    // Streaming pass-through
    for (int k = 1; k <= 5; k++) begin
      step(0, 0, 1, 1, CW'(k), DW'(k * 32'h100));
      chk("stream_ctrl",  64'(ctrl_out),  64'(k));
      chk("stream_ready", 64'(ready_out), 64'd1);
    end
    step(0, 0, 0, 1, 16'h0, 32'h0);
    chk("stream_end", 64'(valid_out), 64'd0);

    // Backpressure: A on output, B in skid
    step(0, 0, 1, 0, 16'h00AA, 32'hA);
    step(0, 0, 1, 0, 16'h00BB, 32'hB);
    chk("bp_head",  64'(ctrl_out),  64'h00AA);
    chk("bp_ready", 64'(ready_out), 64'd0);
    step(0, 0, 0, 1, 16'h0, 32'h0);
    chk("bp_second", 64'(ctrl_out),  64'h00BB);
    chk("bp_ready1", 64'(ready_out), 64'd1);
    step(0, 0, 0, 1, 16'h0, 32'h0);
    chk("bp_empty", 64'(valid_out), 64'd0);

    // Flush while FULL with a beat offered
    step(0, 0, 1, 0, 16'h00C1, 32'hC1);
    step(0, 0, 1, 0, 16'h00C2, 32'hC2);
    step(0, 1, 1, 0, 16'h0077, 32'h77);
    chk("fl_valid", 64'(valid_out), 64'd0);
    chk("fl_ctrl",  64'(ctrl_out),  64'd0);
    chk("fl_ready", 64'(ready_out), 64'd1);
`ifdef PIPE_STAGE_PERF_EN
    chk("fl_cnt", 64'(flush_cnt), 64'd1);
`endif
    step(0, 0, 0, 1, 16'h0, 32'h0);
    chk("fl_no_ghost", 64'(valid_out), 64'd0);

    // Reset while FULL, then a clean beat
    step(0, 0, 1, 0, 16'h00D1, 32'hD1);
    step(0, 0, 1, 0, 16'h00D2, 32'hD2);
    step(1, 0, 1, 1, 16'h00D3, 32'hD3);
    chk("rf_valid", 64'(valid_out), 64'd0);
    chk("rf_ready", 64'(ready_out), 64'd1);
    chk("rf_data",  64'(data_out),  64'd0);
    step(0, 0, 1, 1, 16'h0033, 32'h33);
    chk("rf_first", 64'(ctrl_out), 64'h0033);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(199) == 0, $urandom_range(29) == 0, 1'($urandom),
           $urandom_range(9) < 7, CW'($urandom), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
